serial_add_sub: RTL
===================

# serial_add_sub

Bit-serial N-bit adder/subtractor built around a single full-adder cell and a carry flip-flop. It processes one bit per clock, LSB first, under a start/done handshake. It is the addition-side companion of the team's combinational half-subtractor datapath and serves area-constrained arithmetic paths where latency of WIDTH cycles is acceptable. In subtract mode it reports a borrow with the same meaning as the half-subtractor's borrow output.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request an operation; sampled only when not busy.
- sub  input  1  0 = a+b, 1 = a-b; latched with start.
- a  input  WIDTH  first operand (minuend in sub mode); latched with start.
- b  input  WIDTH  second operand (subtrahend in sub mode); latched with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  sum or difference, registered.
- co_bo  output  1  add mode: carry-out; sub mode: borrow (1 when a < b unsigned).

## Operation
- States: IDLE, RUN, DONE.
- Reset, at any time including mid-RUN, does the following:
  - Sets state to IDLE and busy=0, done=0, result=0, co_bo=0.
  - Clears the internal shift registers, carry and bit counter.
  - Discards any operation in progress; no done pulse follows.
- Start is accepted in IDLE or DONE. On acceptance, at the sampling edge:
  - Load a into shift register A.
  - Load b, or ~b when sub=1, into shift register B.
  - Load carry with sub (0 for add, 1 for subtract; two's complement).
  - Latch sub into mode, clear the bit counter, and go to RUN.
- RUN, at each edge:
  - s = A[0]^B[0]^c; c_next = majority(A[0],B[0],c).
  - Shift A and B right by one. Shift s into the MSB of the internal sum register S.
  - Increment the counter.
- At the edge that processes bit WIDTH-1:
  - Load result from the final S value (including that last bit).
  - Load co_bo with c_next in add mode, or ~c_next in sub mode.
  - Go to DONE.
- DONE lasts one cycle with done=1. Next state is RUN if start=1 (new operands accepted, back-to-back), else IDLE.
- start, a, b and sub are ignored while in RUN. Input changes after acceptance do not affect the running operation.
- result and co_bo change only when entering DONE or on reset. They hold between operations. They never show partial sums.
- Arithmetic is unsigned modulo 2^WIDTH and needs no overflow detection.
- Signed overflow is not reported.

## Timing
- Count the start-sampling edge as edge 0.
- RUN spans edges 1..WIDTH.
- done, result and co_bo are valid in the cycle after edge WIDTH.
- Total latency is WIDTH+1 edges from start to done visible.
- busy=1 exactly during RUN: WIDTH cycles, deasserting in the same cycle done rises.
- Back-to-back operation: start held high in DONE gives a new result every WIDTH+1 cycles.
- If start and rst are high on the same edge, rst wins.
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use WIDTH=8.
- Add: start with a=8'h35, b=8'h4A, sub=0.
  - Required: busy high for 8 cycles; done pulse in the cycle after edge 8; result=8'h7F, co_bo=0.
- Add with wrap: a=8'hFF, b=8'h01, sub=0.
  - Required: result=8'h00, co_bo=1.
  - Follow-up: a=8'h00, b=8'h00 gives result=8'h00, co_bo=0.
- Subtract: a=8'h05, b=8'h03, sub=1.
  - Required: result=8'h02, co_bo=0.
  - Follow-up: a=8'h03, b=8'h05, sub=1 gives result=8'hFE, co_bo=1.
  - Follow-up: a=b=8'hA5 gives result=8'h00, co_bo=0.
- Ignored inputs: start a+b=8'h10+8'h20. Then on edge 3 pulse start with a=8'hFF and toggle a, b and sub.
  - Required: the second start is ignored; a single done with result=8'h30, co_bo=0.
  - Required: result holds 8'h30 for 20 idle cycles afterwards.
- Reset mid-run: start 8'h0F+8'h01, then assert rst for one cycle at edge 4.
  - Required: busy=0, done=0, result=8'h00, co_bo=0 on the next cycle.
  - Required: no done pulse ever follows.
  - Required: a fresh start of 8'h0F+8'h01 yields 8'h10.
- Back-to-back: hold start high with operands 8'h01+8'h02, then 8'h80+8'h80 presented during DONE.
  - Required: done pulses 9 cycles apart.
  - Required: the results are 8'h03/co_bo=0, then 8'h00/co_bo=1.
  - Required: busy low for exactly the one DONE cycle between operations.

Source files
------------

// File: rtl/serial_add_sub_if.sv
// Start/done handshake and operand/result bus for the bit-serial adder/subtractor.
// The master drives the request side and the slave returns status and results.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             co_bo;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, co_bo
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, co_bo
    );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus a carry flop,
// processing one bit per clock LSB first. Subtraction is a + ~b + 1.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_add_sub_if.slave       bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] s_q,      s_d;
    logic             c_q,      c_d;
    logic             mode_q,   mode_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             co_bo_q,  co_bo_d;

    // The single full-adder cell working on the current LSBs.
    logic             sum_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] s_shifted;

    always_comb begin
        sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
        carry_nxt = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
        s_shifted = {sum_bit, s_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        s_d      = s_q;
        c_d      = c_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        co_bo_d  = co_bo_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.sub ? ~bus.b : bus.b;
                    c_d     = bus.sub;
                    mode_d  = bus.sub;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                s_d    = s_shifted;
                c_d    = carry_nxt;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // Carry out of a + ~b + 1 is the inverse of the borrow.
                    result_d = s_shifted;
                    co_bo_d  = mode_q ? ~carry_nxt : carry_nxt;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = DONE;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            s_q      <= '0;
            c_q      <= 1'b0;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            co_bo_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            s_q      <= s_d;
            c_q      <= c_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            co_bo_q  <= co_bo_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.co_bo  = co_bo_q;
endmodule
